// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch controller.
package fetch_pkg;

    localparam int unsigned XLEN_DEF    = 64;
    localparam int unsigned INSTR_W_DEF = 32;
    localparam int unsigned PC_INC      = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_controller.sv
// Sequences PC advance and single-outstanding imem fetches, delivering
// instructions to decode and squashing stale responses on redirect.
module fetch_controller
    import fetch_pkg::*;
#(
    parameter int unsigned XLEN    = XLEN_DEF,
    parameter int unsigned INSTR_W = INSTR_W_DEF,
    parameter int unsigned CNT_W   = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [XLEN-1:0]    pc_in,
    output logic               pc_en,
    output logic               pc_src,
    output logic [XLEN-1:0]    pc_target,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_target,
    output logic               imem_req,
    output logic [XLEN-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [XLEN-1:0]    if_pc,
    input  logic               if_ready,
    output logic [CNT_W-1:0]   fetch_count
);

    fetch_state_e       state, state_d;
    logic               req_d;
    logic [XLEN-1:0]    addr_d;
    logic               valid_d;
    logic [INSTR_W-1:0] instr_d;
    logic [XLEN-1:0]    ifpc_d;
    logic [CNT_W-1:0]   count_d;

    // PC control: redirect wins; sequential advance only when a live fetch returns.
    assign pc_src    = reset & redirect_valid;
    assign pc_target = redirect_target;
    assign pc_en     = reset & (redirect_valid | ((state == S_FETCH) & imem_ack));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            imem_req    <= 1'b0;
            imem_addr   <= '0;
            if_valid    <= 1'b0;
            if_instr    <= '0;
            if_pc       <= '0;
            fetch_count <= '0;
        end else begin
            state       <= state_d;
            imem_req    <= req_d;
            imem_addr   <= addr_d;
            if_valid    <= valid_d;
            if_instr    <= instr_d;
            if_pc       <= ifpc_d;
            fetch_count <= count_d;
        end
    end

    always_comb begin
        state_d = state;
        req_d   = imem_req;
        addr_d  = imem_addr;
        valid_d = if_valid;
        instr_d = if_instr;
        ifpc_d  = if_pc;
        count_d = fetch_count;

        unique case (state)
            // A redirect here means pc_in is stale; sample it one cycle later.
            S_IDLE: begin
                if (!redirect_valid) begin
                    state_d = S_FETCH;
                    addr_d  = pc_in;
                    req_d   = 1'b1;
                end
            end
            S_FETCH: begin
                if (imem_ack) begin
                    req_d = 1'b0;
                    if (redirect_valid) begin
                        state_d = S_IDLE;
                    end else begin
                        instr_d = imem_rdata;
                        ifpc_d  = imem_addr;
                        valid_d = 1'b1;
                        state_d = S_HOLD;
                    end
                end else if (redirect_valid) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (imem_ack) begin
                    req_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            // A handshake coinciding with a redirect still counts; decode squashes it.
            S_HOLD: begin
                if (if_ready) begin
                    count_d = fetch_count + CNT_W'(1);
                end
                if (if_ready || redirect_valid) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_fetch_controller.sv
// Scoreboard bench for fetch_controller with a PC register and imem model.
module tb_fetch_controller;
    import fetch_pkg::*;

    localparam int unsigned XLEN    = 64;
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned CNT_W   = 32;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [XLEN-1:0]    pc_reg;
    logic               pc_en;
    logic               pc_src;
    logic [XLEN-1:0]    pc_target;
    logic               redirect_valid;
    logic [XLEN-1:0]    redirect_target;
    logic               imem_req;
    logic [XLEN-1:0]    imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;
    logic               if_valid;
    logic [INSTR_W-1:0] if_instr;
    logic [XLEN-1:0]    if_pc;
    logic               if_ready;
    logic [CNT_W-1:0]   fetch_count;

    int          tests = 0;
    int          fails = 0;
    logic [63:0] exp_req_q[$];
    logic [63:0] exp_pc_q[$];
    int          ack_delay = 1;
    int          mem_cnt = 0;
    bit          mem_auto = 1'b1;
    bit          mem_pending = 1'b0;
    bit          prev_req = 1'b0;
    logic        snap_pc_en;
    logic        snap_pc_src;
    logic [63:0] snap_pc_target;
    int unsigned exp_count = 0;

    fetch_controller #(.XLEN(XLEN), .INSTR_W(INSTR_W), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .reset           (rst_n),
        .pc_in           (pc_reg),
        .pc_en           (pc_en),
        .pc_src          (pc_src),
        .pc_target       (pc_target),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .if_valid        (if_valid),
        .if_instr        (if_instr),
        .if_pc           (if_pc),
        .if_ready        (if_ready),
        .fetch_count     (fetch_count)
    );

    always #5 clk = ~clk;

    // PC register with load enable, as paired with this block
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     pc_reg <= '0;
        else if (pc_en) pc_reg <= pc_src ? pc_target : pc_reg + XLEN'(PC_INC);
    end

    function automatic logic [31:0] instr_of(input logic [63:0] a);
        return a[31:0] ^ 32'hA5C3_0013;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock cycle, entered and left at the falling edge.
    task automatic cyc();
        logic [63:0] e;
        if (imem_req && !prev_req) begin
            if (exp_req_q.size() == 0) check("req_extra", 64'(exp_req_q.size()), 64'd1);
            else check("req_addr", imem_addr, exp_req_q.pop_front());
        end
        prev_req = imem_req;
        if (mem_auto) begin
            imem_ack = 1'b0;
            if (!imem_req) begin
                mem_pending = 1'b0;
            end else begin
                if (!mem_pending) begin
                    mem_pending = 1'b1;
                    mem_cnt = ack_delay;
                end
                mem_cnt--;
                if (mem_cnt == 0) begin
                    imem_ack    = 1'b1;
                    imem_rdata  = instr_of(imem_addr);
                    mem_pending = 1'b0;
                end
            end
        end
        #1;
        snap_pc_en     = pc_en;
        snap_pc_src    = pc_src;
        snap_pc_target = pc_target;
        if (rst_n && if_valid && if_ready) begin
            exp_count++;
            if (exp_pc_q.size() == 0) begin
                check("hs_extra", 64'(exp_pc_q.size()), 64'd1);
            end else begin
                e = exp_pc_q.pop_front();
                check("if_pc", if_pc, e);
                check("if_instr", 64'(if_instr), 64'(instr_of(e)));
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push_fetch(input logic [63:0] a);
        exp_req_q.push_back(a);
        exp_pc_q.push_back(a);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},   64'(imem_req), 64'd0);
        check({tag, "_addr"},  imem_addr, 64'd0);
        check({tag, "_valid"}, 64'(if_valid), 64'd0);
        check({tag, "_instr"}, 64'(if_instr), 64'd0);
        check({tag, "_ifpc"},  if_pc, 64'd0);
        check({tag, "_count"}, 64'(fetch_count), 64'd0);
        check({tag, "_pc_en"}, 64'(pc_en), 64'd0);
        check({tag, "_pc_src"}, 64'(pc_src), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        redirect_valid = 1'b1;
        redirect_target = 64'h40;
        imem_ack = 1'b0;
        imem_rdata = '0;
        if_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        check_reset_outputs("rst");
        redirect_valid = 1'b0;
        rst_n = 1'b1;

        // Sequential fetches with 1-cycle memory and decode always ready
        push_fetch(64'h0);
        push_fetch(64'h4);
        push_fetch(64'h8);
        repeat (9) cyc();
        check("seq_count", 64'(fetch_count), 64'(exp_count));
        check("seq_count_abs", 64'(fetch_count), 64'd3);

        // Decode stalls for 5 cycles while an instruction is held
        if_ready = 1'b0;
        exp_req_q.push_back(64'hC);
        cyc();
        cyc();
        check("hold_valid", 64'(if_valid), 64'd1);
        check("hold_pc", if_pc, 64'hC);
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("stall_valid", 64'(if_valid), 64'd1);
            check("stall_pc", if_pc, 64'hC);
            check("stall_instr", 64'(if_instr), 64'(instr_of(64'hC)));
            check("stall_req", 64'(imem_req), 64'd0);
            check("stall_count", 64'(fetch_count), 64'd3);
        end
        exp_pc_q.push_back(64'hC);
        if_ready = 1'b1;
        cyc();
        check("stall_release_count", 64'(fetch_count), 64'd4);

        // Redirect while a slow fetch is outstanding: response must be dropped
        ack_delay = 4;
        exp_req_q.push_back(64'h10);
        cyc();
        redirect_valid = 1'b1;
        redirect_target = 64'h100;
        cyc();
        check("drain_pc_en", 64'(snap_pc_en), 64'd1);
        check("drain_pc_src", 64'(snap_pc_src), 64'd1);
        check("drain_req_held", 64'(imem_req), 64'd1);
        check("drain_addr_stable", imem_addr, 64'h10);
        redirect_valid = 1'b0;
        repeat (3) begin
            cyc();
            check("drain_no_valid", 64'(if_valid), 64'd0);
        end
        check("drain_req_done", 64'(imem_req), 64'd0);
        check("drain_pc", pc_reg, 64'h100);
        ack_delay = 1;
        push_fetch(64'h100);
        repeat (3) cyc();
        check("after_drain_count", 64'(fetch_count), 64'd5);

        // Redirect in the same cycle as the ack
        ack_delay = 2;
        exp_req_q.push_back(64'h104);
        cyc();
        cyc();
        redirect_valid = 1'b1;
        redirect_target = 64'h200;
        cyc();
        check("coinc_pc_en", 64'(snap_pc_en), 64'd1);
        check("coinc_pc_src", 64'(snap_pc_src), 64'd1);
        check("coinc_target", snap_pc_target, 64'h200);
        check("coinc_req", 64'(imem_req), 64'd0);
        check("coinc_valid", 64'(if_valid), 64'd0);
        check("coinc_pc", pc_reg, 64'h200);
        redirect_valid = 1'b0;
        ack_delay = 1;
        push_fetch(64'h200);
        repeat (3) cyc();
        check("after_coinc_count", 64'(fetch_count), 64'd6);

        // Redirect in S_HOLD coinciding with a handshake
        push_fetch(64'h204);
        if_ready = 1'b0;
        cyc();
        cyc();
        check("hold_redir_valid", 64'(if_valid), 64'd1);
        if_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_target = 64'h300;
        cyc();
        check("hold_redir_pc_en", 64'(snap_pc_en), 64'd1);
        check("hold_redir_drop", 64'(if_valid), 64'd0);
        check("hold_redir_count", 64'(fetch_count), 64'd7);
        redirect_valid = 1'b0;
        push_fetch(64'h300);
        repeat (3) cyc();
        check("after_hold_count", 64'(fetch_count), 64'(exp_count));

        // Reset mid-fetch; the ack that arrives after release must be ignored
        mem_auto = 1'b0;
        imem_ack = 1'b0;
        cyc();
        check("pre_rst_req", 64'(imem_req), 64'd1);
        check("pre_rst_addr", imem_addr, 64'h304);
        rst_n = 1'b0;
        exp_count = 0;
        #1;
        check_reset_outputs("midrst");
        check("midrst_pc", pc_reg, 64'd0);
        cyc();
        check_reset_outputs("midrst_hold");
        rst_n = 1'b1;
        imem_ack = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        exp_req_q.push_back(64'h0);
        cyc();
        check("late_ack_pc_en", 64'(snap_pc_en), 64'd0);
        check("late_ack_valid", 64'(if_valid), 64'd0);
        check("late_ack_req", 64'(imem_req), 64'd1);
        check("late_ack_addr", imem_addr, 64'h0);
        imem_ack = 1'b0;
        mem_auto = 1'b1;
        mem_pending = 1'b0;
        exp_pc_q.push_back(64'h0);
        cyc();
        cyc();
        check("post_rst_count", 64'(fetch_count), 64'(exp_count));
        check("post_rst_count_abs", 64'(fetch_count), 64'd1);

        check("req_q_empty", 64'(exp_req_q.size()), 64'd0);
        check("pc_q_empty", 64'(exp_pc_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Safety net against a stalled run
    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

endmodule
